// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the serial arithmetic blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_arith_pkg;

    // Default operand/result width of the serial arithmetic units.
    localparam int SERIAL_WIDTH_DEFAULT = 8;

    // Sequencer states for the serial subtractor.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor built entirely from 2:1 muxes.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports:
//   a    - minuend bit
//   b    - subtrahend bit
//   bin  - borrow in
//   d    - difference bit, a ^ b ^ bin
//   bout - borrow out, (~a & b) | (~(a ^ b) & bin)
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic x;

    // x = a ^ b: pass b when a=0, its complement when a=1.
    mux_2_1 u_mux_xor_ab (
        .sel (a),
        .in0 (b),
        .in1 (~b),
        .out (x)
    );

    // d = x ^ bin, same trick with x as the select.
    mux_2_1 u_mux_diff (
        .sel (x),
        .in0 (bin),
        .in1 (~bin),
        .out (d)
    );

    // When the bits differ (x=1) a borrow happens exactly when b is the 1,
    // so b itself is the borrow; when they match the incoming borrow ripples.
    mux_2_1 u_mux_borrow (
        .sel (x),
        .in0 (bin),
        .in1 (b),
        .out (bout)
    );

endmodule

// File: rtl/mux_2_1.sv
// Generic 1-bit 2:1 multiplexer, the basic cell of the mux-built arithmetic.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports:
//   sel - select; 0 picks in0, 1 picks in1
//   in0 - data input chosen when sel=0
//   in1 - data input chosen when sel=1
//   out - selected data
module mux_2_1 (
    input  logic sel,
    input  logic in0,
    input  logic in1,
    output logic out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, diff = a - b, LSB first, one bit per clock.
// Latency: busy for WIDTH cycles after the accepting edge, then a one-cycle done pulse.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped.
//
// Optional build macro: SERIAL_SUB_SIGNED_EN adds the overflow output
// (two's-complement overflow of the last job). Without it the port and its
// register do not exist; unsigned behaviour is the same in both builds.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-high reset
//   start      - request pulse, accepted only in IDLE
//   a, b       - minuend / subtrahend, captured on acceptance
//   busy       - high while bits are being processed
//   done       - one-cycle pulse when diff/borrow_out are fresh
//   diff       - a - b modulo 2^WIDTH, held until the next completion
//   borrow_out - final borrow, 1 iff a < b unsigned
//   overflow   - (SERIAL_SUB_SIGNED_EN only) signed overflow of the last job
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_SIGNED_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             bin;
    logic [CW-1:0]    count;

    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] res_next;

    full_subtractor_bit u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bin),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // New difference bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
    assign res_next = {cell_d, res_sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            bin        <= 1'b0;
            count      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
            overflow   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        res_sr <= '0;
                        bin    <= 1'b0;
                        count  <= '0;
                        state  <= SHIFT;
                    end
                end

                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    bin    <= cell_bout;
                    count  <= count + CW'(1);
                    // Outputs are published only from the MSB step so they
                    // stay frozen while a job is in flight.
                    if (count == LAST_BIT) begin
                        state      <= DONE;
                        diff       <= res_next;
                        borrow_out <= cell_bout;
`ifdef SERIAL_SUB_SIGNED_EN
                        // Signed overflow: carry into the sign bit differs from carry out.
                        overflow   <= bin ^ cell_bout;
`endif
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_SIGNED_EN
    logic         overflow;
`endif

    int n_checks = 0;
    int n_errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_SIGNED_EN
        ,
        .overflow   (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide subtraction gives borrow in bit W.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} - {1'b0, y};
    endfunction

    // Signed overflow: operand signs differ and result sign differs from minuend.
    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] r;
        r = ref_sub(x, y);
        return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    // Runs one job. The acceptance edge counts as edge 1, so done must be
    // visible after edge W+1. When hold is set, start stays high with other
    // operands for the whole job and must be ignored.
    task automatic do_job(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input bit hold, input logic [W-1:0] ha, input logic [W-1:0] hb);
        int         edges;
        int         busy_n;
        bit         seen;
        bit         stable;
        bit         overlap;
        logic [W-1:0] d0;
        logic       b0;
        logic [W:0] r;

        @(negedge clk);
        check("idle_busy", busy, 0);
        d0 = diff;
        b0 = borrow_out;
        start = 1'b1;
        a = ta;
        b = tb;
        @(posedge clk);
        edges = 1;
        #1;
        if (hold) begin
            a = ha;
            b = hb;
        end else begin
            start = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
        end
        seen = 0; busy_n = 0; stable = 1; overlap = 0;
        while (!seen && edges < 40) begin
            @(negedge clk);
            if (busy && done) overlap = 1;
            if (done) seen = 1;
            else begin
                if (busy) busy_n++;
                if (diff !== d0 || borrow_out !== b0) stable = 0;
                @(posedge clk);
                edges++;
            end
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        check("latency_edges", edges, W + 1);
        check("busy_cycles", busy_n, W);
        check("busy_done_overlap", overlap, 0);
        check("outputs_frozen", stable, 1);
        r = ref_sub(ta, tb);
        check("diff", diff, r[W-1:0]);
        check("borrow_out", borrow_out, r[W]);
`ifdef SERIAL_SUB_SIGNED_EN
        check("overflow", overflow, ref_ovf(ta, tb));
`endif
    endtask

    initial begin
        int  dn;
        logic [W:0] r;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);
`ifdef SERIAL_SUB_SIGNED_EN
        check("rst_overflow", overflow, 0);
`endif
        rst = 1'b0;

        // Directed cases, back-to-back.
        do_job(8'd200, 8'd55, 0, 8'd0, 8'd0);
        do_job(8'd5, 8'd10, 0, 8'd0, 8'd0);
        do_job(8'd0, 8'd0, 0, 8'd0, 8'd0);
        do_job(8'd0, 8'hFF, 0, 8'd0, 8'd0);
        do_job(8'd77, 8'd77, 0, 8'd0, 8'd0);

        // start held high with other operands throughout the job.
        do_job(8'd100, 8'd30, 1, 8'd1, 8'd1);
        @(negedge clk);
        check("hold_no_restart_busy", busy, 0);
        check("hold_no_restart_done", done, 0);
        check("hold_result_kept", diff, 8'd70);

        // Reset during the 4th SHIFT cycle discards the job.
        start = 1'b1; a = 8'd9; b = 8'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_diff", diff, 0);
        check("midrst_borrow", borrow_out, 0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        check("no_done_after_rst", dn, 0);
        do_job(8'd9, 8'd3, 0, 8'd0, 8'd0);

`ifdef SERIAL_SUB_SIGNED_EN
        do_job(8'h80, 8'h01, 0, 8'd0, 8'd0);
        check("sgn_ovf_set", overflow, 1);
        do_job(8'h10, 8'h01, 0, 8'd0, 8'd0);
        check("sgn_ovf_clear", overflow, 0);
`endif

        // Random sweep.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            do_job(ra, rb, 0, 8'd0, 8'd0);
        end

        // Result persists in IDLE.
        r = ref_sub(8'd200, 8'd55);
        do_job(8'd200, 8'd55, 0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        check("idle_hold_diff", diff, r[W-1:0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
